// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - MDU_WIDTH    : default operand width
//   - Funct codes  : MULT, MULTU, DIV, DIVU, MTHI, MTLO
//   - mdu_state_e  : controller state encoding
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // Signed variants take absolute values on entry and sign-correct in FIX.
    function automatic logic funct_is_signed(input logic [5:0] funct);
        return (funct == MULT) || (funct == DIV);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the CPU control path and the HI/LO unit.
//   master (CPU side) : drives Start, Funct, Src1, Src2; sees Busy, Done, Hi, Lo, DivZero
//   slave  (unit side): the reverse
interface mdu_if #(
    parameter int WIDTH = mdu_pkg::MDU_WIDTH
);
    logic             Start;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] Src1;
    logic [WIDTH-1:0] Src2;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivZero;

    modport master (
        output Start, Funct, Src1, Src2,
        input  Busy, Done, Hi, Lo, DivZero
    );

    modport slave (
        input  Start, Funct, Src1, Src2,
        output Busy, Done, Hi, Lo, DivZero
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling for the multiply/divide unit.
// Entry path : abs1/abs2 are |src1|/|src2| for signed ops (raw otherwise),
//              neg1/neg2 flag which operands were negative.
// FIX path   : conditionally negates the 2*WIDTH product, the quotient and
//              the remainder.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    input  logic               is_signed,
    output logic [WIDTH-1:0]   abs1,
    output logic [WIDTH-1:0]   abs2,
    output logic               neg1,
    output logic               neg2,
    input  logic [2*WIDTH-1:0] prod_in,
    input  logic               prod_neg,
    output logic [2*WIDTH-1:0] prod_out,
    input  logic [WIDTH-1:0]   quo_in,
    input  logic               quo_neg,
    output logic [WIDTH-1:0]   quo_out,
    input  logic [WIDTH-1:0]   rem_in,
    input  logic               rem_neg,
    output logic [WIDTH-1:0]   rem_out
);
    assign neg1 = is_signed & src1[WIDTH-1];
    assign neg2 = is_signed & src2[WIDTH-1];

    // The most negative value maps onto itself, which is exactly the
    // unsigned magnitude the iterative datapath needs.
    assign abs1 = neg1 ? -src1 : src1;
    assign abs2 = neg2 ? -src2 : src2;

    assign prod_out = prod_neg ? -prod_in : prod_in;
    assign quo_out  = quo_neg  ? -quo_in  : quo_in;
    assign rem_out  = rem_neg  ? -rem_in  : rem_in;
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO arithmetic unit: mult/multu (radix-2 shift-add),
// div/divu (restoring), mthi/mtlo (single-cycle register writes).
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : Start/Funct/Src1/Src2 request; Busy, one-cycle Done,
//                  Hi, Lo and sticky DivZero results
//
// state   | meaning
// ST_IDLE | waiting for Start; mthi/mtlo complete here
// ST_MUL  | one multiplier bit per cycle, WIDTH cycles
// ST_DIV  | one quotient bit per cycle, WIDTH cycles
// ST_FIX  | sign correction, Hi/Lo write, Done on the following cycle
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    mdu_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e state_q, state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               res_neg_q;
    logic               dvd_neg_q;
    logic               op_div_q;
    logic               dz_pend_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dz_q;
    logic               done_q;

    logic is_mul, is_div, is_mthi, is_mtlo, start_ok;

    assign is_mul   = (bus.Funct == MULT) || (bus.Funct == MULTU);
    assign is_div   = (bus.Funct == DIV)  || (bus.Funct == DIVU);
    assign is_mthi  = (bus.Funct == MTHI);
    assign is_mtlo  = (bus.Funct == MTLO);
    assign start_ok = (state_q == ST_IDLE) && bus.Start;

    logic [WIDTH-1:0]   abs1, abs2;
    logic               neg1, neg2;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .src1      (bus.Src1),
        .src2      (bus.Src2),
        .is_signed (funct_is_signed(bus.Funct)),
        .abs1      (abs1),
        .abs2      (abs2),
        .neg1      (neg1),
        .neg2      (neg2),
        .prod_in   (acc_q),
        .prod_neg  (res_neg_q),
        .prod_out  (prod_fix),
        .quo_in    (quo_q),
        .quo_neg   (res_neg_q),
        .quo_out   (quo_fix),
        .rem_in    (rem_q),
        .rem_neg   (dvd_neg_q),
        .rem_out   (rem_fix)
    );

    // Shift-add step: acc = {partial product, unconsumed multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                               : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: the remainder always stays below the divisor, so the
    // WIDTH-bit difference is exact whenever the subtraction is taken.
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, opnd_q};
    assign div_diff = rem_sh[WIDTH-1:0] - opnd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok && is_mul)      state_d = ST_MUL;
                else if (start_ok && is_div) state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_neg_q <= 1'b0;
            dvd_neg_q <= 1'b0;
            op_div_q  <= 1'b0;
            dz_pend_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok && (is_mul || is_div)) begin
                        cnt_q     <= '0;
                        opnd_q    <= is_mul ? abs1 : abs2;
                        acc_q     <= {{WIDTH{1'b0}}, abs2};
                        quo_q     <= abs1;
                        rem_q     <= '0;
                        res_neg_q <= neg1 ^ neg2;
                        dvd_neg_q <= neg1;
                        op_div_q  <= is_div;
                        dz_pend_q <= is_div && (bus.Src2 == '0);
                        dz_q      <= 1'b0;
                    end else if (start_ok && is_mthi) begin
                        hi_q   <= bus.Src1;
                        done_q <= 1'b1;
                    end else if (start_ok && is_mtlo) begin
                        lo_q   <= bus.Src1;
                        done_q <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_DIV: begin
                    rem_q <= div_ge ? div_diff : rem_sh[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], div_ge};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_FIX: begin
                    if (op_div_q) begin
                        // With a zero divisor every step subtracts nothing, so
                        // the sign-fixed remainder is the original dividend.
                        lo_q <= dz_pend_q ? '1 : quo_fix;
                        hi_q <= rem_fix;
                        dz_q <= dz_pend_q;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy    = (state_q != ST_IDLE);
    assign bus.Done    = done_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.DivZero = dz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus hand-written
// sequences for re-issued Start, back-to-back issue and mid-operation reset.
module tb_mul_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    mdu_if #(.WIDTH(32)) bus();

    mul_div_unit #(.WIDTH(32)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   overlap  = 0;
    exp_t sb_q[$];
    vec_t vecs[14];

    always @(negedge clk) begin
        if (!rst && bus.Busy && bus.Done) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, bus.Hi, e.hi);
            chk({tag, "_lo"}, bus.Lo, e.lo);
            chk({tag, "_dz"}, {31'd0, bus.DivZero}, {31'd0, e.dz});
        end
    endtask

    // Start is high for exactly one cycle (cycle 0); returns at the start of cycle 1.
    task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.Start = 1'b1;
        bus.Funct = f;
        bus.Src1  = a;
        bus.Src2  = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int n;
        int busy_n;
        bit seen;
        bit is_mt;
        is_mt  = (v.funct == MTHI) || (v.funct == MTLO);
        drive_start(v.funct, v.src1, v.src2);
        sb_q.push_back('{v.hi, v.lo, v.dz});
        n      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.Done) seen = 1'b1;
            else if (bus.Busy) busy_n++;
        end
        chk({tag, "_latency"}, n, is_mt ? 32'd1 : 32'd34);
        chk({tag, "_busy_cycles"}, busy_n, is_mt ? 32'd0 : 32'd33);
        if (seen) sb_check(tag);
        else begin
            chk({tag, "_done_seen"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        int   done_n;
        int   done_at;
        int   busy_n;
        vec_t v;

        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{MTLO,  32'h00001234, 32'h00000000, 32'h00000005, 32'h00001234, 1'b1};
        vecs[6]  = '{MTHI,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00001234, 1'b1};
        vecs[7]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[10] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[12] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[13] = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Funct = 6'd0;
        bus.Src1  = 32'd0;
        bus.Src2  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_done", {31'd0, bus.Done}, 32'd0);
        chk("reset_hi", bus.Hi, 32'd0);
        chk("reset_lo", bus.Lo, 32'd0);
        chk("reset_dz", {31'd0, bus.DivZero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Undefined Funct: nothing happens, Hi/Lo keep the last product.
        drive_start(6'b100000, 32'h1111, 32'h2222);
        done_n = 0;
        busy_n = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.Done) done_n++;
            if (bus.Busy) busy_n++;
        end
        chk("bad_funct_done", done_n, 32'd0);
        chk("bad_funct_busy", busy_n, 32'd0);
        chk("bad_funct_hi", bus.Hi, 32'h00000001);
        chk("bad_funct_lo", bus.Lo, 32'h23456780);

        // Start re-pulsed while busy is ignored; a new Start in the Done cycle is taken.
        drive_start(MULTU, 32'd3, 32'd4);
        sb_q.push_back('{32'd0, 32'd12, 1'b0});
        done_n  = 0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 35) begin
                chk("b2b_mtlo_done", {31'd0, bus.Done}, 32'd1);
                chk("b2b_mtlo_lo", bus.Lo, 32'h55);
                chk("b2b_mtlo_hi", bus.Hi, 32'h0);
                bus.Start = 1'b0;
            end else if (bus.Done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = c;
                    sb_check("repulse");
                end
            end
            if (c == 4) begin
                bus.Start = 1'b1;
                bus.Funct = DIVU;
                bus.Src1  = 32'd9;
                bus.Src2  = 32'd3;
            end
            if (c == 5) bus.Start = 1'b0;
            if (c == 34 && bus.Done) begin
                bus.Start = 1'b1;
                bus.Funct = MTLO;
                bus.Src1  = 32'h55;
                bus.Src2  = 32'h0;
            end
        end
        chk("repulse_done_cycle", done_at, 32'd34);
        chk("repulse_done_count", done_n, 32'd1);

        // Reset mid-divide abandons the operation.
        v = '{DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1};
        run_op("pre_rst_dz", v);
        drive_start(DIVU, 32'd100, 32'd7);
        done_n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.Done) done_n++;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                chk("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
                chk("rst_mid_hi", bus.Hi, 32'd0);
                chk("rst_mid_lo", bus.Lo, 32'd0);
                chk("rst_mid_dz", {31'd0, bus.DivZero}, 32'd0);
                rst = 1'b0;
            end
        end
        chk("rst_mid_no_done", done_n, 32'd0);

        chk("busy_done_overlap", overlap, 32'd0);
        chk("sb_leftover", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle HI/LO arithmetic unit for the MIPS CPU. It executes mult/multu/div/divu and mthi/mtlo, which the single-cycle ALU cannot handle. The control path issues a request with Start, waits while Busy is high, and takes the result on the one-cycle Done pulse. Hi and Lo are architectural registers, so they hold their values until the next accepted write.

Parameters:
WIDTH, 32, operand width; Hi and Lo are each WIDTH wide; iteration count equals WIDTH.

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  reset, synchronous, active-high
Start  input  1  request strobe; sampled only in IDLE
Funct  input  6  operation code, sampled with Start
Src1  input  WIDTH  multiplicand / dividend / mthi-mtlo source
Src2  input  WIDTH  multiplier / divisor
Busy  output  1  high while an iterative operation is in progress
Done  output  1  one-cycle pulse; Hi, Lo and DivZero are valid from this cycle on
Hi  output  WIDTH  HI register (product upper half / remainder)
Lo  output  WIDTH  LO register (product lower half / quotient)
DivZero  output  1  last accepted divide had Src2==0; held until the next accepted Start

Behaviour:
- Reset: rst_i=1 at an edge forces IDLE.
  - Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, counter=0.
  - This applies in any state: a reset mid-operation abandons it, and no Done follows.
- Funct codes:
  - MULT=011000, MULTU=011001, DIV=011010, DIVU=011011, MTHI=010001, MTLO=010011.
  - Start with any other code is ignored: no state change, no Done.
- States: IDLE, MUL, DIV, FIX.
- IDLE, Start=1, iterative op:
  - Latch |Src1| and |Src2| (raw values for the unsigned ops).
  - Latch the quotient/product sign and the dividend sign.
  - Clear the counter and DivZero.
  - Go to MUL or DIV.
- MUL: radix-2 shift-add, one multiplier bit per cycle. 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle. (WIDTH+1)-bit partial remainder.
- Both MUL and DIV run exactly WIDTH cycles, then go to FIX.
- FIX, one cycle:
  - Negate the 64-bit product if signs differ (MULT only).
  - Negate the quotient if signs differ; the remainder takes the sign of the dividend (DIV only).
  - Write Hi/Lo at the end of FIX, then go to IDLE with Done=1 for exactly one cycle.
- Latency: Start high in cycle 0 → Busy high in cycles 1..33 → Done=1 and Busy=0 in cycle 34.
  - A new Start is accepted in cycle 34.
- MTHI/MTLO in IDLE:
  - Hi<=Src1 (MTHI) or Lo<=Src1 (MTLO) at that edge. The other register is unchanged.
  - Done=1 in the next cycle. Busy stays 0. DivZero unchanged.
- Start while Busy or during FIX: ignored entirely. Operands are not re-latched.
- Divide by zero (DIV or DIVU with Src2==0):
  - Runs the full 34-cycle latency.
  - Lo=all-ones, Hi=Src1 as originally presented, DivZero=1.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0, no flag.
- Hi/Lo never change except at FIX or an MTHI/MTLO write.
- Busy and Done are never high together.

Decomposition:
- Shared package mdu_pkg:
  - Funct localparams: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
  - State encoding: IDLE, MUL, DIV, FIX.
  - WIDTH default.
- One natural sub-module, mdu_sign_fix: combinational abs/negate of operands and results, shared by the entry and FIX paths.
- The rest (FSM, counter, accumulators, Hi/Lo) stays in mul_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, Start in cycle 0 → Busy cycles 1..33; Done in cycle 34; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT 0xFFFFFFFD (−3) × 0x00000007 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then DIV −7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIVU 7/2 → Lo=3, Hi=1.
- DIVU 5/0 → DivZero=1, Lo=0xFFFFFFFF, Hi=5. Then MTLO 0x1234 → Lo=0x1234 next cycle with a Done pulse, Hi=5 unchanged, DivZero still 1.
- DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0, DivZero=0.
- Start MULTU 3×4; re-pulse Start with DIVU 9/3 in cycle 5 → ignored; Done in cycle 34 with Hi=0, Lo=12; only one Done pulse.
- Start DIVU in cycle 0; rst_i=1 in cycle 10 → cycle 11: Busy=0, Hi=Lo=0, DivZero=0; no Done through cycle 40.
